// File: rtl/softreg_bridge.sv
// Bridge from the shell soft-register port (no backpressure) to the shim req/resp handshake.
// Optional status register, answered locally at STATS_ADDR: define SOFTREG_BRIDGE_STATS_EN.

module srb_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp, rp;
   logic [CW-1:0]    cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
         if (pop)  rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= din;
   end

   assign dout  = mem[rp];
   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));
endmodule

module softreg_bridge #(
   parameter int          LOG_DEPTH       = 4,
   parameter int          MAX_OUTSTANDING = 8,
   parameter logic [31:0] STATS_ADDR      = 32'hFFFF_FFF0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        softreg_read_in,
   input  logic        softreg_write_in,
   input  logic [31:0] softreg_addr_in,
   input  logic [63:0] softreg_wrdata_in,
   output logic [63:0] softreg_rddata_out,
   output logic        softreg_rdvalid_out,
   output logic        shim_req_valid_out,
   input  logic        shim_req_ready_in,
   output logic [31:0] shim_req_addr_out,
   output logic [63:0] shim_req_wdata_out,
   output logic        shim_req_wr_out,
   input  logic        shim_resp_valid_in,
   output logic        shim_resp_ready_out,
   input  logic [63:0] shim_resp_rdata_in,
   output logic [15:0] drop_count_out,
   output logic        overflow_out,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_out
);
   localparam int OW       = $clog2(MAX_OUTSTANDING + 1);
   localparam int RQ_DEPTH = 1 << LOG_DEPTH;

   typedef struct packed {
      logic        loc;
      logic        wr;
      logic [31:0] addr;
      logic [63:0] wdata;
   } req_t;

   typedef struct packed {
      logic loc;
      logic wr;
   } tag_t;

   req_t          cap, head;
   tag_t          tag_in, tag_head;
   logic          req_strobe;
   logic          rq_push, rq_pop, rq_empty, rq_full;
   logic          tq_push, tq_pop, tq_empty, tq_full;
   logic          can_issue, issue, local_issue;
   logic          resp_fire, local_resp, vld_in;
   logic [OW-1:0] outstanding;
   logic [63:0]   stats_word;

   assign req_strobe = softreg_read_in | softreg_write_in;
   assign cap.wr     = softreg_write_in;
   assign cap.addr   = softreg_addr_in;
   assign cap.wdata  = softreg_wrdata_in;

`ifdef SOFTREG_BRIDGE_STATS_EN
   assign cap.loc = softreg_read_in & ~softreg_write_in & (softreg_addr_in == STATS_ADDR);

   always_comb begin
      stats_word          = '0;
      stats_word[63]      = overflow_out;
      stats_word[32 +: OW] = outstanding;
      stats_word[15:0]    = drop_count_out;
   end
`else
   logic unused_stats;
   assign cap.loc      = 1'b0;
   assign stats_word   = '0;
   assign unused_stats = ^STATS_ADDR;
`endif

   // Full is judged on the pre-pop count, so a same-cycle pop never frees a slot.
   assign rq_push = req_strobe & ~rq_full;

   srb_fifo #(.WIDTH($bits(req_t)), .DEPTH(RQ_DEPTH)) u_req_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rq_push),
      .din   (cap),
      .pop   (rq_pop),
      .dout  (head),
      .empty (rq_empty),
      .full  (rq_full)
   );

   // Tag space is checked too: local entries hold tags without counting as outstanding.
   assign can_issue   = ~rq_empty & ~head.loc & (outstanding < OW'(MAX_OUTSTANDING)) & ~tq_full;
   assign issue       = can_issue & shim_req_ready_in;
   assign local_issue = ~rq_empty & head.loc & ~tq_full;
   assign rq_pop      = issue | local_issue;

   assign shim_req_valid_out = can_issue;
   assign shim_req_addr_out  = rq_empty ? '0 : head.addr;
   assign shim_req_wdata_out = rq_empty ? '0 : head.wdata;
   assign shim_req_wr_out    = ~rq_empty & head.wr;

   assign tq_push    = rq_pop;
   assign tag_in.loc = head.loc;
   assign tag_in.wr  = head.wr;

   srb_fifo #(.WIDTH($bits(tag_t)), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tq_push),
      .din   (tag_in),
      .pop   (tq_pop),
      .dout  (tag_head),
      .empty (tq_empty),
      .full  (tq_full)
   );

   assign shim_resp_ready_out = ~tq_empty & ~tag_head.loc;
   assign resp_fire           = shim_resp_ready_out & shim_resp_valid_in;
   assign local_resp          = ~tq_empty & tag_head.loc;
   assign tq_pop              = resp_fire | local_resp;
   assign vld_in              = (resp_fire & ~tag_head.wr) | local_resp;
   assign outstanding_out     = outstanding;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         softreg_rdvalid_out <= 1'b0;
         softreg_rddata_out  <= '0;
         outstanding         <= '0;
         drop_count_out      <= '0;
         overflow_out        <= 1'b0;
      end else begin
         softreg_rdvalid_out <= vld_in;
         if (vld_in) softreg_rddata_out <= local_resp ? stats_word : shim_resp_rdata_in;
         case ({issue, resp_fire})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         if (req_strobe & rq_full) begin
            overflow_out <= 1'b1;
            if (drop_count_out != 16'hFFFF) drop_count_out <= drop_count_out + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_softreg_bridge.sv
// Directed bench for softreg_bridge: queue-level model checked every cycle, plus literal pins.
module tb_softreg_bridge;
   localparam logic [31:0] SADDR = 32'hFFFF_FFF0;

   logic        clk = 1'b0;
   logic        rst;
   logic        softreg_read_in, softreg_write_in;
   logic [31:0] softreg_addr_in;
   logic [63:0] softreg_wrdata_in;
   logic [63:0] softreg_rddata_out;
   logic        softreg_rdvalid_out;
   logic        shim_req_valid_out, shim_req_ready_in;
   logic [31:0] shim_req_addr_out;
   logic [63:0] shim_req_wdata_out;
   logic        shim_req_wr_out;
   logic        shim_resp_valid_in, shim_resp_ready_out;
   logic [63:0] shim_resp_rdata_in;
   logic [15:0] drop_count_out;
   logic        overflow_out;
   logic [3:0]  outstanding_out;

   softreg_bridge #(.LOG_DEPTH(4), .MAX_OUTSTANDING(8), .STATS_ADDR(SADDR)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .softreg_read_in     (softreg_read_in),
      .softreg_write_in    (softreg_write_in),
      .softreg_addr_in     (softreg_addr_in),
      .softreg_wrdata_in   (softreg_wrdata_in),
      .softreg_rddata_out  (softreg_rddata_out),
      .softreg_rdvalid_out (softreg_rdvalid_out),
      .shim_req_valid_out  (shim_req_valid_out),
      .shim_req_ready_in   (shim_req_ready_in),
      .shim_req_addr_out   (shim_req_addr_out),
      .shim_req_wdata_out  (shim_req_wdata_out),
      .shim_req_wr_out     (shim_req_wr_out),
      .shim_resp_valid_in  (shim_resp_valid_in),
      .shim_resp_ready_out (shim_resp_ready_out),
      .shim_resp_rdata_in  (shim_resp_rdata_in),
      .drop_count_out      (drop_count_out),
      .overflow_out        (overflow_out),
      .outstanding_out     (outstanding_out)
   );

   always #5 clk = ~clk;

   typedef struct { bit loc; bit wr; bit [31:0] addr; bit [63:0] wdata; } ent_t;
   typedef struct { bit wr; bit [31:0] addr; int cyc; } pnd_t;

   // Model: request queue, tag queue (0 read, 1 write, 2 local), shim pending list, shim memory.
   ent_t        rq[$];
   int          tq[$];
   pnd_t        pend[$];
   bit [63:0]   smem [bit [31:0]];
   int          out_m, drop_m;
   bit          ovf_m, rdv_m;
   bit [63:0]   rd_m;

   int          credits, cyc, vectors, errors, pulses, p0, n0;
   bit          stray;
   bit [63:0]   last_pulse;
   logic [31:0] issued[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      rq.delete(); tq.delete(); pend.delete();
      out_m = 0; drop_m = 0; ovf_m = 0; rdv_m = 0; rd_m = '0;
   endtask

   // One clock: drive the shim response, compare against the model, advance the model.
   task automatic tick();
      bit sv, mv, mrr, full, tfull, nrdv;
      bit [63:0] rdat, stw, nrd;
      ent_t h;
      int t;
      sv = stray || (credits > 0 && pend.size() > 0 && (cyc - pend[0].cyc) >= 2);
      rdat = '0;
      if (pend.size() > 0 && !pend[0].wr && smem.exists(pend[0].addr)) rdat = smem[pend[0].addr];
      shim_resp_valid_in = sv;
      shim_resp_rdata_in = rdat;

      mv  = rq.size() > 0 && !rq[0].loc && out_m < 8 && tq.size() < 8;
      mrr = tq.size() > 0 && tq[0] != 2;
      chk("req_valid", 64'(shim_req_valid_out), 64'(mv));
      if (mv) begin
         chk("req_addr", 64'(shim_req_addr_out), 64'(rq[0].addr));
         chk("req_wdata", shim_req_wdata_out, rq[0].wdata);
         chk("req_wr", 64'(shim_req_wr_out), 64'(rq[0].wr));
      end
      chk("resp_ready", 64'(shim_resp_ready_out), 64'(mrr));
      chk("rdvalid", 64'(softreg_rdvalid_out), 64'(rdv_m));
      chk("rddata", softreg_rddata_out, rd_m);
      chk("drop_count", 64'(drop_count_out), 64'(drop_m));
      chk("overflow", 64'(overflow_out), 64'(ovf_m));
      chk("outstanding", 64'(outstanding_out), 64'(out_m));
      if (softreg_rdvalid_out) begin pulses++; last_pulse = softreg_rddata_out; end
      if (shim_req_valid_out && shim_req_ready_in) issued.push_back(shim_req_addr_out);

      full  = rq.size() >= 16;
      tfull = tq.size() >= 8;
      stw = '0;
      stw[63] = ovf_m;
      stw[47:32] = out_m[15:0];
      stw[15:0] = drop_m[15:0];
      nrdv = 0;
      nrd = rd_m;
      if (mrr && sv) begin
         t = tq.pop_front();
         void'(pend.pop_front());
         out_m--;
         if (credits > 0) credits--;
         if (t == 0) begin nrdv = 1; nrd = rdat; end
      end else if (tq.size() > 0 && tq[0] == 2) begin
         void'(tq.pop_front());
         nrdv = 1;
         nrd = stw;
      end
      if (mv && shim_req_ready_in) begin
         h = rq.pop_front();
         tq.push_back(h.wr ? 1 : 0);
         out_m++;
         pend.push_back('{h.wr, h.addr, cyc});
         if (h.wr) smem[h.addr] = h.wdata;
      end else if (rq.size() > 0 && rq[0].loc && !tfull) begin
         void'(rq.pop_front());
         tq.push_back(2);
      end
      if (softreg_read_in || softreg_write_in) begin
         if (full) begin
            ovf_m = 1;
            if (drop_m < 16'hFFFF) drop_m++;
         end else begin
`ifdef SOFTREG_BRIDGE_STATS_EN
            h.loc = softreg_read_in && !softreg_write_in && softreg_addr_in == SADDR;
`else
            h.loc = 0;
`endif
            h.wr = softreg_write_in;
            h.addr = softreg_addr_in;
            h.wdata = softreg_wrdata_in;
            rq.push_back(h);
         end
      end
      rdv_m = nrdv;
      rd_m = nrd;
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic host_req(input bit wr, input logic [31:0] a, input logic [63:0] d);
      softreg_read_in = !wr;
      softreg_write_in = wr;
      softreg_addr_in = a;
      softreg_wrdata_in = d;
      tick();
      softreg_read_in = 0;
      softreg_write_in = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vectors = 0; errors = 0; pulses = 0; cyc = 0; credits = 0; stray = 0;
      rst = 0;
      softreg_read_in = 0; softreg_write_in = 0; softreg_addr_in = '0; softreg_wrdata_in = '0;
      shim_req_ready_in = 0; shim_resp_valid_in = 0; shim_resp_rdata_in = '0;
      model_reset();
      smem[32'h10] = 64'h1234;
      repeat (3) @(negedge clk);
      chk("rst_rdvalid", 64'(softreg_rdvalid_out), 64'd0);
      chk("rst_rddata", softreg_rddata_out, 64'd0);
      chk("rst_req_valid", 64'(shim_req_valid_out), 64'd0);
      chk("rst_resp_ready", 64'(shim_resp_ready_out), 64'd0);
      chk("rst_drop", 64'(drop_count_out), 64'd0);
      chk("rst_outstanding", 64'(outstanding_out), 64'd0);
      rst = 1;
      idle(2);

      // Single read, shim answers two cycles after issue.
      shim_req_ready_in = 1; credits = 1000; p0 = pulses;
      host_req(0, 32'h10, '0);
      chk("t1_valid_n1", 64'(shim_req_valid_out), 64'd1);
      chk("t1_addr", 64'(shim_req_addr_out), 64'h10);
      chk("t1_wr", 64'(shim_req_wr_out), 64'd0);
      idle(8);
      chk("t1_pulses", 64'(pulses - p0), 64'd1);
      chk("t1_data", last_pulse, 64'h1234);
      chk("t1_outstanding", 64'(outstanding_out), 64'd0);

      // Write then read-back: only the read produces a pulse.
      p0 = pulses;
      host_req(1, 32'h20, 64'hAB);
      host_req(0, 32'h20, '0);
      idle(10);
      chk("t2_pulses", 64'(pulses - p0), 64'd1);
      chk("t2_data", last_pulse, 64'hAB);

      // Overflow: 20 writes with the shim stalled.
      shim_req_ready_in = 0;
      for (int i = 0; i < 20; i++) begin
         softreg_write_in = 1; softreg_addr_in = 32'h100 + i; softreg_wrdata_in = 64'(i);
         tick();
      end
      softreg_write_in = 0;
      chk("t3_drop", 64'(drop_count_out), 64'd4);
      chk("t3_overflow", 64'(overflow_out), 64'd1);
      issued.delete();
      shim_req_ready_in = 1;
      idle(40);
      chk("t3_count", 64'(issued.size()), 64'd16);
      for (int i = 0; i < 16 && i < issued.size(); i++) chk("t3_order", 64'(issued[i]), 64'(32'h100 + i));

      n0 = issued.size(); p0 = pulses;
      host_req(0, SADDR, '0);
      idle(5);
      chk("stats_pulses", 64'(pulses - p0), 64'd1);
`ifdef SOFTREG_BRIDGE_STATS_EN
      chk("stats_ovf_bit", 64'(last_pulse[63]), 64'd1);
      chk("stats_drop", 64'(last_pulse[15:0]), 64'd4);
      chk("stats_no_issue", 64'(issued.size()), 64'(n0));
`else
      chk("stats_fwd_issue", 64'(issued.size()), 64'(n0 + 1));
      if (issued.size() > 0) chk("stats_fwd_addr", 64'(issued[issued.size()-1]), 64'(SADDR));
`endif

      // Outstanding limit: 10 reads, no responses.
      credits = 0; issued.delete();
      for (int i = 0; i < 10; i++) begin
         softreg_read_in = 1; softreg_addr_in = 32'h200 + i;
         tick();
      end
      softreg_read_in = 0;
      idle(5);
      chk("t4_issued8", 64'(issued.size()), 64'd8);
      chk("t4_outstanding", 64'(outstanding_out), 64'd8);
      chk("t4_valid_low", 64'(shim_req_valid_out), 64'd0);
      credits = 1;
      tick();
      chk("t4_valid_again", 64'(shim_req_valid_out), 64'd1);
      tick();
      chk("t4_issued9", 64'(issued.size()), 64'd9);
      credits = 1000;
      idle(30);

      // Simultaneous issue and response at outstanding 3.
      credits = 0;
      for (int i = 0; i < 3; i++) host_req(0, 32'h300 + i, '0);
      idle(3);
      shim_req_ready_in = 0;
      host_req(0, 32'h303, '0);
      idle(1);
      chk("t5_pre", 64'(outstanding_out), 64'd3);
      shim_req_ready_in = 1; credits = 1;
      tick();
      chk("t5_same_cycle", 64'(outstanding_out), 64'd3);

      // Reset in the middle of traffic.
      credits = 1000;
      host_req(0, 32'h10, '0);
      host_req(1, 32'h30, 64'h5);
      #2 rst = 0;
      #1;
      chk("mr_req_valid", 64'(shim_req_valid_out), 64'd0);
      chk("mr_resp_ready", 64'(shim_resp_ready_out), 64'd0);
      chk("mr_rdvalid", 64'(softreg_rdvalid_out), 64'd0);
      chk("mr_rddata", softreg_rddata_out, 64'd0);
      chk("mr_outstanding", 64'(outstanding_out), 64'd0);
      chk("mr_overflow", 64'(overflow_out), 64'd0);
      chk("mr_addr", 64'(shim_req_addr_out), 64'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      stray = 1;
      idle(3);
      chk("mr_stray_ignored", 64'(shim_resp_ready_out), 64'd0);
      stray = 0;
      p0 = pulses;
      host_req(0, 32'h10, '0);
      idle(8);
      chk("mr_after_pulses", 64'(pulses - p0), 64'd1);
      chk("mr_after_data", last_pulse, 64'h1234);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/softreg_bridge.md
Name: softreg_bridge

Overview:
- Buffered, flow-controlled bridge between the shell soft-register port and the CatapultShim softreg req/resp handshake.
- The shell port has no backpressure, so this block supplies it:
  - queues requests in a request FIFO;
  - limits requests outstanding at the shim;
  - tracks request type in order, so only read responses reach the shell;
  - counts requests dropped on overflow.
- Sits in Role between the softreg_*_in/out shell ports and the io_softreg_* ports of the shim.

Parameters:
- LOG_DEPTH, 4, log2 of request FIFO depth (16 entries).
- MAX_OUTSTANDING, 8, maximum requests issued to the shim and not yet answered; also the tag FIFO depth.
- STATS_ADDR, 32'hFFFF_FFF0, softreg address answered locally when SOFTREG_BRIDGE_STATS_EN is defined.

Ports:
- clk  in  1  user clock; all logic in this domain.
- rst  in  1  asynchronous, active-low reset.
- softreg_read_in  in  1  shell read strobe.
- softreg_write_in  in  1  shell write strobe.
- softreg_addr_in  in  32  shell address.
- softreg_wrdata_in  in  64  shell write data.
- softreg_rddata_out  out  64  read data to shell.
- softreg_rdvalid_out  out  1  one-cycle read-data-valid pulse to shell.
- shim_req_valid_out  out  1  request valid to shim.
- shim_req_ready_in  in  1  shim accepts request.
- shim_req_addr_out  out  32  request address.
- shim_req_wdata_out  out  64  request write data.
- shim_req_wr_out  out  1  1 = write, 0 = read.
- shim_resp_valid_in  in  1  shim response valid; one response per request, reads and writes.
- shim_resp_ready_out  out  1  bridge accepts response.
- shim_resp_rdata_in  in  64  response data.
- drop_count_out  out  16  saturating count of dropped requests.
- overflow_out  out  1  sticky; set on first drop.
- outstanding_out  out  4  current outstanding count, width $clog2(MAX_OUTSTANDING+1).

Behaviour:
- Reset (rst low, asynchronous):
  - request FIFO and tag FIFO empty; outstanding = 0;
  - drop_count_out = 0, overflow_out = 0;
  - all outputs 0, including softreg_rddata_out and softreg_rdvalid_out.
  - Reset mid-operation discards all queued and outstanding state; responses arriving after reset are not accepted (shim_resp_ready_out = 0).
- Capture:
  - A cycle with softreg_read_in | softreg_write_in is a request; wr = softreg_write_in, so both strobes high means write.
  - Pushed as {wr, addr, wdata} if the request FIFO is not full.
  - If the FIFO is full, the request is dropped: drop_count_out increments, saturating at 16'hFFFF, and overflow_out is set.
  - A pop in the same cycle does not free a slot for that cycle's push; full is evaluated before the pop.
- Issue:
  - shim_req_valid_out = FIFO not empty AND outstanding < MAX_OUTSTANDING.
  - Data outputs show the FIFO head; the FIFO is first-word-fall-through.
  - A request captured in cycle N is visible on shim_req_valid_out at N+1 at the earliest.
  - On valid && ready: pop the request FIFO, push wr into the tag FIFO, outstanding +1.
  - Valid may drop without a handshake only when the outstanding limit is reached; otherwise the head is held until accepted.
- Response:
  - shim_resp_ready_out = tag FIFO not empty.
  - On valid && ready: pop the tag and decrement outstanding.
  - Tag wr = 0: softreg_rddata_out <= rdata and softreg_rdvalid_out pulses high for exactly one cycle, the next cycle.
  - Tag wr = 1: response discarded, no pulse.
  - softreg_rddata_out holds its last value between pulses.
- Issue and response handshaking in the same cycle leaves outstanding unchanged.
- Responses are consumed strictly in issue order.
- Dropped reads produce no response; software detects them via drop_count_out.

Optional Feature:
- Macro: SOFTREG_BRIDGE_STATS_EN.
- When defined:
  - A read with addr == STATS_ADDR is enqueued as a local entry.
  - At the FIFO head, a local entry is not presented to the shim. It pops and pushes a local tag, which needs tag space, and does not count toward outstanding.
  - When the local tag reaches the tag FIFO head, the bridge pulses softreg_rdvalid_out with data [63] = overflow_out, [47:32] = outstanding zero-extended, [15:0] = drop_count_out, all other bits 0, sampled that cycle.
  - No shim handshake occurs for the local entry; shell read order is preserved.
- When not defined: STATS_ADDR is forwarded like any other address.

Test Plan:
- Read addr 0x10; shim ready = 1, responds 64'h1234 two cycles later -> request with wr = 0, addr = 0x10 at cycle N+1; rdvalid pulses one cycle with 64'h1234; outstanding returns to 0.
- Write 0x20 = 0xAB, then read 0x20; shim answers both with 0 then 0xAB -> exactly one rdvalid pulse, data 0xAB.
- shim_req_ready_in = 0; 20 back-to-back writes -> 16 queued, drop_count_out = 4, overflow_out = 1; release ready -> 16 handshakes in original order.
- Ready = 1, no responses; 10 reads -> exactly 8 handshakes, then valid low with outstanding = 8; one response -> ninth issued the next cycle.
- Issue and response handshake in the same cycle with outstanding = 3 -> outstanding stays 3; then assert rst low mid-traffic -> all outputs 0 immediately and the FIFOs are empty after release.
- With SOFTREG_BRIDGE_STATS_EN, after the overflow test, read STATS_ADDR -> rdvalid with data[63] = 1 and data[15:0] = 4; no shim request issued.
